// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: command and response valid/ready channels of the register-file sequencer.
// Revision: 1.0
`default_nettype none

interface regfile_sequencer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic       cmd_dst;
   logic [7:0] cmd_imm;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic       res_flag;

   modport master (
      output cmd_valid, cmd_op, cmd_dst, cmd_imm, res_ready,
      input  cmd_ready, res_valid, res_data, res_flag
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_dst, cmd_imm, res_ready,
      output cmd_ready, res_valid, res_data, res_flag
   );
endinterface

`default_nettype wire

// File: rtl/regfile_sequencer.sv
// +---------------------------------------------------------------------------+
// | regfile_sequencer: command-driven controller for a two-entry 8-bit        |
// | register file with LOADI/ADD/SUB/READ operations.   Revision: 1.0         |
// +---------------------------------------------------------------------------+
`default_nettype none

module regfile_sequencer (
   input  wire logic             sysclk,
   input  wire logic             rst_n,
   regfile_sequencer_if.slave    bus,
   output      logic [7:0]       rf_w,
   output      logic             rf_rw,
   output      logic             rf_wsel,
   output      logic [1:0]       rf_rsel,
   input  wire logic [7:0]       rf_read0,
   input  wire logic [7:0]       rf_read1
);

   localparam logic [1:0] c_OP_LOADI = 2'b00;
   localparam logic [1:0] c_OP_ADD   = 2'b01;
   localparam logic [1:0] c_OP_SUB   = 2'b10;
   localparam logic [1:0] c_OP_READ  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       w_accept;

   logic [1:0] r_op;
   logic       r_dst;
   logic [7:0] r_wdata;
   logic [7:0] r_res_data;
   logic       r_flag;

   logic [8:0] w_sum;
   logic [7:0] w_diff;

   assign w_sum  = {1'b0, rf_read0} + {1'b0, rf_read1};
   assign w_diff = rf_read0 - rf_read1;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next        = r_state;
      w_accept      = 1'b0;
      bus.cmd_ready = 1'b0;
      bus.res_valid = 1'b0;
      rf_rw         = 1'b0;
      rf_wsel       = 1'b0;
      rf_rsel       = 2'b01;
      case (r_state)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               w_accept = 1'b1;
               w_next   = (bus.cmd_op == c_OP_LOADI) ? ST_WR : ST_RD;
            end
         end
         ST_RD:   w_next = ST_CAP;
         ST_CAP:  w_next = (r_op == c_OP_READ) ? ST_RESP : ST_WR;
         ST_WR: begin
            rf_rw   = 1'b1;
            rf_wsel = r_dst;
            w_next  = ST_RESP;
         end
         ST_RESP: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Operands are taken from the register-file read ports in CAP, one cycle after RD.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_op       <= c_OP_LOADI;
         r_dst      <= 1'b0;
         r_wdata    <= 8'h00;
         r_res_data <= 8'h00;
         r_flag     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op  <= bus.cmd_op;
            r_dst <= bus.cmd_dst;
            if (bus.cmd_op == c_OP_LOADI) begin
               r_wdata    <= bus.cmd_imm;
               r_res_data <= bus.cmd_imm;
               r_flag     <= 1'b0;
            end
         end
         if (r_state == ST_CAP) begin
            case (r_op)
               c_OP_ADD: begin
                  r_wdata    <= w_sum[7:0];
                  r_res_data <= w_sum[7:0];
                  r_flag     <= w_sum[8];
               end
               c_OP_SUB: begin
                  r_wdata    <= w_diff;
                  r_res_data <= w_diff;
                  r_flag     <= (rf_read0 < rf_read1);
               end
               c_OP_READ: begin
                  r_res_data <= r_dst ? rf_read1 : rf_read0;
                  r_flag     <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

   assign rf_w         = r_wdata;
   assign bus.res_data = r_res_data;
   assign bus.res_flag = r_flag;

endmodule

`default_nettype wire
